led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Parametrised one-hot LED selector/sequencer driven by debounced, active-low, single-cycle key pulses.
- Drives N active-low LEDs in one of three modes: SELECT (key i lights LED i), CHASE (lit LED rotates on a prescaled tick) and BLINK (selected LED flashes).
- Sits between the key debounce/pulse generator and the board LED pins.
- Generalises the fixed 4-key selector to N channels and adds timed modes.

Parameters:
- N, 4, number of keys/LEDs; legal range 2..32.
- PERIOD, 25_000_000, clk cycles per tick (CHASE step / BLINK half-period); legal minimum 2.
- IW, $clog2(N), width of the selected-index output (localparam, derived).

Ports:
- clk  input  1  system clock.
- rstn_signal  input  1  asynchronous, active-low reset.
- key_pulse  input  N  active-low, one-cycle key pulses; bit i selects channel i.
- mode_pulse  input  1  active-low, one-cycle pulse; advances mode.
- dir  input  1  CHASE direction: 0 = index up, 1 = index down; sampled at each tick.
- led  output  N  active-low LED drive; registered.
- mode  output  2  current mode: 0 = SELECT, 1 = CHASE, 2 = BLINK; registered.
- sel_idx  output  IW  currently selected channel index; registered.

Behaviour:
- Reset (asynchronous on rstn_signal low):
  - mode = SELECT, sel_idx = 0, tick counter = 0, blink phase = ON.
  - led = all ones except bit 0 = 0.
- Key priority: if several key_pulse bits are low in the same cycle, the lowest index wins.
- Latency: a key or mode pulse sampled at edge k is reflected on led, sel_idx and mode after edge k; all outputs come straight from registers.
- Tick counter:
  - Counts 0..PERIOD-1 and wraps to 0.
  - tick = 1 in the cycle where the count equals PERIOD-1.
  - Runs in CHASE and BLINK; held at 0 in SELECT.
  - Any key pulse or mode pulse clears the counter to 0 (restart).
- Mode FSM: SELECT -> CHASE -> BLINK -> SELECT, one step per mode_pulse. A mode transition sets blink phase = ON.
- SELECT mode:
  - Key i sets sel_idx = i.
  - led = ~(1 << sel_idx).
  - No key pulse: hold.
- CHASE mode:
  - On tick: dir=0 -> sel_idx increments, wrapping N-1 -> 0; dir=1 -> sel_idx decrements, wrapping 0 -> N-1.
  - A key pulse sets sel_idx = i; that cycle's tick is suppressed because the counter restarts.
  - led = ~(1 << sel_idx).
- BLINK mode:
  - On tick, phase toggles.
  - led = ~(1 << sel_idx) when phase = ON, all ones when OFF.
  - A key pulse sets sel_idx = i and forces phase = ON.
- Simultaneous mode_pulse and key pulse in the same cycle: both take effect. The new mode is entered, sel_idx is set to the key index, the counter is cleared and phase = ON.
- A key pulse whose index equals the current sel_idx still restarts the counter and sets phase = ON.
- Reset asserted mid-tick or mid-blink: immediate return to reset values with no residual count.
- Undefined mode encoding 3 is unreachable; if it is ever entered, the next edge forces SELECT.

Optional Feature:
- Macro: LEDSEQ_BLINK_EN.
- Defined: BLINK mode exists; the mode cycle is SELECT -> CHASE -> BLINK -> SELECT.
- Undefined: no blink phase register or BLINK mode. The mode cycle is SELECT -> CHASE -> SELECT, and mode never reports 2.

Test Plan (N=4, PERIOD=4, LEDSEQ_BLINK_EN defined):
- Reset release, no inputs for 20 cycles -> led=4'b1110, mode=0, sel_idx=0 throughout.
- SELECT: key_pulse=4'b1011 for 1 cycle -> next edge led=4'b1011, sel_idx=2. Then key_pulse=4'b0101 (keys 1 and 3) -> led=4'b1101 (lowest index wins).
- CHASE, dir=0, start sel_idx=3: one mode_pulse -> mode=1; sel_idx steps 3->0->1 every 4 cycles (wrap). Set dir=1 at sel_idx=1 -> next tick sel_idx=0, then 3.
- BLINK from sel_idx=1 -> led alternates 4'b1101 / 4'b1111 every 4 cycles. key_pulse bit 3 mid-OFF phase -> next edge led=4'b0111 and the counter restarts (next toggle 4 cycles later).
- mode_pulse and key_pulse=4'b1110 in the same cycle while in BLINK -> next edge mode=0, sel_idx=0, led=4'b1110, no further toggling.
- Assert rstn_signal low for 1 cycle mid-CHASE (counter=2, sel_idx=2) -> led=4'b1110 asynchronously, mode=0. After release, no spurious tick.
- With LEDSEQ_BLINK_EN undefined: two mode_pulses from reset -> mode goes 0->1->0 and never reports 2.

Source files
------------

// File: rtl/led_sequencer.sv
// led_sequencer: N-channel one-hot active-low LED selector with SELECT, CHASE and BLINK modes.
// BLINK mode and its phase register exist only when LEDSEQ_BLINK_EN is defined.
module led_sequencer #(
    parameter  int N      = 4,
    parameter  int PERIOD = 25_000_000,
    localparam int IW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn_signal,
    input  logic [N-1:0]  key_pulse,
    input  logic          mode_pulse,
    input  logic          dir,
    output logic [N-1:0]  led,
    output logic [1:0]    mode,
    output logic [IW-1:0] sel_idx
);
    localparam int CW = $clog2(PERIOD);

    typedef enum logic [1:0] {SEL = 2'd0, CHASE = 2'd1, BLINK = 2'd2, BAD = 2'd3} mode_t;

    mode_t         mode_q, mode_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] key_idx, sel_n;
    logic [N-1:0]  led_n;
    logic          key_any, restart, timed, tick, phase, phase_n;

    always_comb begin
        key_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (!key_pulse[i]) key_idx = IW'(i);
        key_any = ~&key_pulse;
        restart = key_any | ~mode_pulse;
        timed   = (mode_q == CHASE) | (mode_q == BLINK);
        // a restarting pulse swallows the tick of its own cycle
        tick    = timed & (cnt == CW'(PERIOD - 1)) & ~restart;
        cnt_n   = (restart | ~timed | tick) ? '0 : cnt + CW'(1);
`ifdef LEDSEQ_BLINK_EN
        mode_n  = (mode_q == BAD) ? SEL : mode_pulse ? mode_q :
                  (mode_q == SEL) ? CHASE : (mode_q == CHASE) ? BLINK : SEL;
`else
        mode_n  = (mode_q == BAD || mode_q == BLINK) ? SEL : mode_pulse ? mode_q :
                  (mode_q == SEL) ? CHASE : SEL;
`endif
        sel_n   = key_any ? key_idx :
                  !(tick && mode_q == CHASE) ? sel_idx :
                  dir ? ((sel_idx == '0) ? IW'(N - 1) : sel_idx - IW'(1)) :
                        ((sel_idx == IW'(N - 1)) ? '0 : sel_idx + IW'(1));
`ifdef LEDSEQ_BLINK_EN
        phase_n = restart ? 1'b1 : (tick && mode_q == BLINK) ? ~phase : phase;
        led_n   = (mode_n == BLINK && !phase_n) ? '1 : ~(N'(1) << sel_n);
`else
        phase_n = 1'b1;
        led_n   = ~(N'(1) << sel_n);
`endif
    end

    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            mode_q  <= SEL;
            sel_idx <= '0;
            cnt     <= '0;
            led     <= ~N'(1);
        end else begin
            mode_q  <= mode_n;
            sel_idx <= sel_n;
            cnt     <= cnt_n;
            led     <= led_n;
        end
    end

`ifdef LEDSEQ_BLINK_EN
    always_ff @(posedge clk or negedge rstn_signal)
        if (!rstn_signal) phase <= 1'b1;
        else phase <= phase_n;
`else
    assign phase = 1'b1;
`endif

    assign mode = mode_q;
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_led_sequencer;
    localparam int N = 4, PERIOD = 4;
`ifdef LEDSEQ_BLINK_EN
    localparam int NMODES = 3;
`else
    localparam int NMODES = 2;
`endif

    logic         clk = 0, rstn_signal = 0, mode_pulse = 1, dir = 0;
    logic [N-1:0] key_pulse = '1, led;
    logic [1:0]   mode, sel_idx;
    int           n_chk = 0, n_pass = 0;
    int           m_mode, m_sel, m_age, k;
    bit           m_on, kp, mp, tk, live = 0;

    always #5 clk = ~clk;

    led_sequencer #(.N(N), .PERIOD(PERIOD)) dut (
        .clk(clk), .rstn_signal(rstn_signal), .key_pulse(key_pulse),
        .mode_pulse(mode_pulse), .dir(dir), .led(led), .mode(mode), .sel_idx(sel_idx)
    );

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // reference: ticks fall every PERIOD cycles of uninterrupted time in a timed mode
    always @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            m_mode = 0; m_sel = 0; m_age = 0; m_on = 1;
        end else begin
            k = -1;
            for (int i = N - 1; i >= 0; i--) if (!key_pulse[i]) k = i;
            kp = (k >= 0);
            mp = !mode_pulse;
            tk = m_mode != 0 && (m_age + 1) % PERIOD == 0 && !kp && !mp;
            if (kp) m_sel = k;
            else if (tk && m_mode == 1) m_sel = dir ? (m_sel + N - 1) % N : (m_sel + 1) % N;
            if (kp || mp) m_on = 1;
            else if (tk && m_mode == 2) m_on = !m_on;
            m_age = (kp || mp || m_mode == 0) ? 0 : m_age + 1;
            if (mp) m_mode = (m_mode + 1) % NMODES;
        end
    end

    always @(negedge clk) if (live) begin
        check("model_led", led, (m_mode == 2 && !m_on) ? (1 << N) - 1 : ((1 << N) - 1) ^ (1 << m_sel));
        check("model_mode", mode, m_mode);
        check("model_sel", sel_idx, m_sel);
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic [N-1:0] kv, logic mv);
        key_pulse = kv;
        mode_pulse = mv;
        @(negedge clk);
        key_pulse = '1;
        mode_pulse = 1;
    endtask

    initial begin
        #12 rstn_signal = 1;
        @(negedge clk);
        live = 1;
        step(20);
        check("rst_led", led, 4'b1110);
        check("rst_mode", mode, 0);
        check("rst_sel", sel_idx, 0);
        press(4'b1011, 1);
        check("sel_led", led, 4'b1011);
        check("sel_idx", sel_idx, 2);
        press(4'b0101, 1);
        check("prio_led", led, 4'b1101);
        check("prio_sel", sel_idx, 1);
        press(4'b0111, 1);
        press('1, 0);
        check("chase_mode", mode, 1);
        check("chase_start", sel_idx, 3);
        step(3);
        check("chase_hold", sel_idx, 3);
        step(1);
        check("chase_wrap", sel_idx, 0);
        step(4);
        check("chase_up", sel_idx, 1);
        dir = 1;
        step(4);
        check("chase_down", sel_idx, 0);
        step(4);
        check("chase_wrap_down", sel_idx, 3);
        check("chase_led", led, 4'b0111);
        dir = 0;
`ifdef LEDSEQ_BLINK_EN
        press(4'b1101, 1);
        press('1, 0);
        check("blink_mode", mode, 2);
        check("blink_on", led, 4'b1101);
        step(4);
        check("blink_off", led, 4'b1111);
        step(2);
        press(4'b0111, 1);
        check("blink_key", led, 4'b0111);
        step(3);
        check("blink_restart_hold", led, 4'b0111);
        step(1);
        check("blink_restart_toggle", led, 4'b1111);
        press(4'b1110, 0);
        check("combo_mode", mode, 0);
        check("combo_sel", sel_idx, 0);
        check("combo_led", led, 4'b1110);
        step(10);
        check("combo_steady", led, 4'b1110);
`else
        press('1, 0);
        check("chase_exit", mode, 0);
`endif
        press(4'b1011, 1);
        press('1, 0);
        step(2);
        #2 rstn_signal = 0;
        #1;
        check("async_led", led, 4'b1110);
        check("async_mode", mode, 0);
        check("async_sel", sel_idx, 0);
        @(negedge clk);
        #2 rstn_signal = 1;
        step(8);
        check("post_rst_led", led, 4'b1110);
        check("post_rst_sel", sel_idx, 0);
        press('1, 0);
        check("cycle_1", mode, 1);
        press('1, 0);
        check("cycle_2", mode, NMODES == 3 ? 2 : 0);
        step(2);
        live = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
